// File: rtl/cim_pkg.sv
// Shared types and sizing helpers for the CIM crossbar tile.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } cim_state_t;

  // $clog2 with a floor of 1 so single-entry fields still get a real bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_cols(input int xbar_size, input int data_size);
    return xbar_size / data_size;
  endfunction

  // Worst case is XBAR_SIZE products of two DATA_SIZE-bit values.
  function automatic int calc_acc_w(input int data_size, input int xbar_size);
    return 2 * data_size + $clog2(xbar_size);
  endfunction

  function automatic int calc_num_addr(input int xbar_size, input int bus_width);
    return (xbar_size + bus_width - 1) / bus_width;
  endfunction

endpackage

// File: rtl/cim_tile_if.sv
// Controller-facing CIM interface: RD buffer writes, start/ready handshake
// and the result bus.
interface cim_tile_if
  import cim_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int XBAR_SIZE = 32,
  parameter int BUS_WIDTH = 16
);
  localparam int NUM_ADDR = calc_num_addr(XBAR_SIZE, BUS_WIDTH);
  localparam int ADDR_W   = clog2_min1(NUM_ADDR);
  localparam int PASS_W   = clog2_min1(DATA_SIZE);
  localparam int COLS     = calc_cols(XBAR_SIZE, DATA_SIZE);
  localparam int ACC_W    = calc_acc_w(DATA_SIZE, XBAR_SIZE);

  logic                  i_cim_we;
  logic [ADDR_W-1:0]     i_addr;
  logic [BUS_WIDTH-1:0]  i_data;
  logic                  i_cim_start;
  logic                  o_cim_ready;
  logic [COLS*ACC_W-1:0] o_acc;
  logic                  o_valid;
  logic [PASS_W-1:0]     o_pass;

  modport master (
    output i_cim_we, i_addr, i_data, i_cim_start,
    input  o_cim_ready, o_acc, o_valid, o_pass
  );

  modport slave (
    input  i_cim_we, i_addr, i_data, i_cim_start,
    output o_cim_ready, o_acc, o_valid, o_pass
  );

endinterface

// File: rtl/cim_col_mac.sv
// One crossbar column accumulator. The first row of a pass either clears the
// accumulator (pass 0) or doubles it, since inputs arrive MSB-first.
module cim_col_mac #(
  parameter int DATA_SIZE = 4,
  parameter int ACC_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_first,
  input  logic                 i_clr,
  input  logic [DATA_SIZE-1:0] i_weight,
  output logic [ACC_W-1:0]     o_acc
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_add;

  assign w_base = i_clr ? '0 : {r_acc[ACC_W-2:0], 1'b0};
  assign w_add  = i_en ? ACC_W'(i_weight) : '0;

  // Shift-or-clear on the first row of a pass, plain accumulate afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_first) begin
      r_acc <= w_base + w_add;
    end else if (i_en) begin
      r_acc <= r_acc + w_add;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cim_tile.sv
// Digital CIM crossbar tile: weight store, 1-bit row-driver buffer and a
// row-per-cycle bit-plane MAC feeding one accumulator per output column.
//
// state   | meaning
// IDLE    | ready; accepts RD/weight writes and start
// COMPUTE | processes one crossbar row per cycle
// DONE    | advances the pass index, flags a finished result
module cim_tile
  import cim_pkg::*;
#(
  parameter  int DATA_SIZE = 4,
  parameter  int XBAR_SIZE = 32,
  parameter  int BUS_WIDTH = 16,
  localparam int COLS      = calc_cols(XBAR_SIZE, DATA_SIZE),
  localparam int ACC_W     = calc_acc_w(DATA_SIZE, XBAR_SIZE),
  localparam int NUM_ADDR  = calc_num_addr(XBAR_SIZE, BUS_WIDTH),
  localparam int ADDR_W    = clog2_min1(NUM_ADDR),
  localparam int PASS_W    = clog2_min1(DATA_SIZE),
  localparam int ROW_W     = clog2_min1(XBAR_SIZE),
  localparam int COL_W     = clog2_min1(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  cim_tile_if.slave            bus,
  input  logic                 i_w_we,
  input  logic [ROW_W-1:0]     i_w_row,
  input  logic [COL_W-1:0]     i_w_col,
  input  logic [DATA_SIZE-1:0] i_w_data
);

  cim_state_t           r_state;
  logic [ROW_W-1:0]     r_row;
  logic [PASS_W-1:0]    r_pass;
  logic                 r_valid;
  logic [XBAR_SIZE-1:0] r_rd;
  logic [DATA_SIZE-1:0] r_w [XBAR_SIZE][COLS];

  logic w_idle;
  logic w_compute;
  logic w_first;
  logic w_clr;
  logic w_row_en;
  logic w_last_row;
  logic w_pass_wrap;

  assign w_idle      = (r_state == IDLE);
  assign w_compute   = (r_state == COMPUTE);
  assign w_first     = w_compute && (r_row == '0);
  assign w_clr       = w_first && (r_pass == '0);
  assign w_row_en    = w_compute && r_rd[r_row];
  assign w_last_row  = (r_row == ROW_W'(XBAR_SIZE - 1));
  assign w_pass_wrap = (r_pass == PASS_W'(DATA_SIZE - 1));

  // Sequencer: IDLE -> COMPUTE (XBAR_SIZE rows) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_pass  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_cim_start) begin
            r_state <= COMPUTE;
            r_row   <= '0;
          end
        end
        COMPUTE: begin
          if (w_last_row) begin
            r_state <= DONE;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_row   <= '0;
          r_pass  <= w_pass_wrap ? '0 : r_pass + 1'b1;
          r_valid <= w_pass_wrap;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RD buffer slice write; rows past XBAR_SIZE and unused addresses fall away
  // because no row decodes to them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
    end else if (w_idle && bus.i_cim_we) begin
      for (int j = 0; j < XBAR_SIZE; j++) begin
        if (bus.i_addr == ADDR_W'(j / BUS_WIDTH)) begin
          r_rd[j] <= bus.i_data[j % BUS_WIDTH];
        end
      end
    end
  end

  // Weight store write, decoded per cell so out-of-range indices hit nothing.
  always_ff @(posedge clk) begin
    if (w_idle && i_w_we) begin
      for (int r = 0; r < XBAR_SIZE; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (i_w_row == ROW_W'(r) && i_w_col == COL_W'(c)) begin
            r_w[r][c] <= i_w_data;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ACC_W-1:0] w_acc;

    cim_col_mac #(
      .DATA_SIZE (DATA_SIZE),
      .ACC_W     (ACC_W)
    ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_row_en),
      .i_first  (w_first),
      .i_clr    (w_clr),
      .i_weight (r_w[r_row][c]),
      .o_acc    (w_acc)
    );

    assign bus.o_acc[c*ACC_W +: ACC_W] = w_acc;
  end

  assign bus.o_cim_ready = w_idle;
  assign bus.o_valid     = r_valid;
  assign bus.o_pass      = r_pass;

endmodule
